// File: rtl/reg_file.sv
// 32 x WIDTH general-purpose register file: two combinational read ports, one
// synchronous write port, r0 hardwired to zero, write-first bypass on reads.
module reg_file #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADDR-1:0]  read_reg1,
  input  logic [ADDR-1:0]  read_reg2,
  input  logic [ADDR-1:0]  write_reg,
  input  logic [WIDTH-1:0] write_data,
  input  logic             reg_write,
  output logic [WIDTH-1:0] read_data1,
  output logic [WIDTH-1:0] read_data2
);

  localparam int DEPTH = 1 << ADDR;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             write_en;

  assign write_en = reg_write && (write_reg != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (write_en) begin
      regs[write_reg] <= write_data;
    end
  end

  // Reset also masks the bypass so both ports read zero while it is held.
  function automatic logic [WIDTH-1:0] read_port(
    input logic [ADDR-1:0]  addr,
    input logic [WIDTH-1:0] stored,
    input logic             rst,
    input logic             wen,
    input logic [ADDR-1:0]  waddr,
    input logic [WIDTH-1:0] wdata
  );
    logic [WIDTH-1:0] result;
    result = stored;
    if (rst || addr == '0) begin
      result = '0;
    end else if (wen && addr == waddr) begin
      result = wdata;
    end
    return result;
  endfunction

  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    read_data1 = read_port(read_reg1, regs[read_reg1], reset, write_en, write_reg, write_data);
    read_data2 = read_port(read_reg2, regs[read_reg2], reset, write_en, write_reg, write_data);
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file with hand-computed expectations.
module tb_reg_file;

  localparam int WIDTH = 32;
  localparam int ADDR  = 5;

  logic             clk;
  logic             reset;
  logic [ADDR-1:0]  read_reg1;
  logic [ADDR-1:0]  read_reg2;
  logic [ADDR-1:0]  write_reg;
  logic [WIDTH-1:0] write_data;
  logic             reg_write;
  logic [WIDTH-1:0] read_data1;
  logic [WIDTH-1:0] read_data2;

  int errors = 0;
  int checks = 0;

  reg_file #(.WIDTH(WIDTH), .ADDR(ADDR)) dut (
    .clk        (clk),
    .reset      (reset),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .reg_write  (reg_write),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [ADDR-1:0] addr, input logic [WIDTH-1:0] data);
    @(negedge clk);
    write_reg  = addr;
    write_data = data;
    reg_write  = 1'b1;
    @(posedge clk);
    #1;
    reg_write  = 1'b0;
  endtask

  task automatic read_both(input logic [ADDR-1:0] a1, input logic [ADDR-1:0] a2);
    read_reg1 = a1;
    read_reg2 = a2;
    #1;
  endtask

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] op_a, op_b;

  initial begin
    reset      = 1'b1;
    read_reg1  = 5'd13;
    read_reg2  = 5'd22;
    write_reg  = 5'd4;
    write_data = 32'h1234_abcd;
    reg_write  = 1'b1;
    #2;

    // Reset sweep with a pending write asserted; edges occur during the sweep.
    for (int i = 0; i < 32; i++) begin
      read_both(i[ADDR-1:0], 5'(31 - i));
      check("rst_rd1", read_data1, '0);
      check("rst_rd2", read_data2, '0);
    end
    @(negedge clk);
    reg_write = 1'b0;
    reset     = 1'b0;
    read_both(5'd4, 5'd4);
    check("rst_no_write_r4", read_data1, '0);

    // Write/read feeding ALU operands
    do_write(5'd1, 32'ha5a5_a5a5);
    do_write(5'd2, 32'h5a5a_5a5a);
    read_both(5'd1, 5'd2);
    check("rd_r1", read_data1, 32'ha5a5_a5a5);
    check("rd_r2", read_data2, 32'h5a5a_5a5a);
    op_a = read_data1;
    op_b = read_data2;
    check("alu_and", op_a & op_b, 32'h0000_0000);
    check("alu_or",  op_a | op_b, 32'hffff_ffff);
    sum = {1'b0, op_a} + {1'b0, op_b};
    check("alu_add", sum[WIDTH-1:0], 32'hffff_ffff);
    sum = {1'b0, op_a} + {1'b0, ~op_b} + 33'd1;
    check("alu_sub", sum[WIDTH-1:0], 32'h4b4b_4b4b);
    check("alu_cout", {31'd0, sum[WIDTH]}, 32'd1);

    // r0 protection, including no bypass to address 0
    @(negedge clk);
    write_reg  = 5'd0;
    write_data = 32'hdead_beef;
    reg_write  = 1'b1;
    read_both(5'd0, 5'd0);
    check("r0_pre_rd1", read_data1, '0);
    check("r0_pre_rd2", read_data2, '0);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    read_both(5'd0, 5'd1);
    check("r0_post", read_data1, '0);
    check("r0_r1_kept", read_data2, 32'ha5a5_a5a5);

    // Bypass
    do_write(5'd3, 32'h0000_0011);
    @(negedge clk);
    write_reg  = 5'd3;
    write_data = 32'h0000_0022;
    reg_write  = 1'b0;
    read_both(5'd3, 5'd3);
    check("nobyp_rd1", read_data1, 32'h0000_0011);
    check("nobyp_rd2", read_data2, 32'h0000_0011);
    reg_write = 1'b1;
    #1;
    check("byp_pre_rd1", read_data1, 32'h0000_0022);
    check("byp_pre_rd2", read_data2, 32'h0000_0022);
    @(posedge clk);
    #1;
    check("byp_post_rd1", read_data1, 32'h0000_0022);
    check("byp_post_rd2", read_data2, 32'h0000_0022);
    reg_write = 1'b0;
    #1;
    check("byp_stored", read_data1, 32'h0000_0022);

    // Independent per-port bypass
    @(negedge clk);
    write_reg  = 5'd1;
    write_data = 32'h0000_0077;
    reg_write  = 1'b1;
    read_both(5'd3, 5'd1);
    check("indep_rd1", read_data1, 32'h0000_0022);
    check("indep_rd2", read_data2, 32'h0000_0077);
    reg_write = 1'b0;
    #1;
    check("indep_rd2_nobyp", read_data2, 32'ha5a5_a5a5);

    // Async reset mid-cycle discards pending write
    do_write(5'd5, 32'h1234_5678);
    read_both(5'd5, 5'd1);
    check("r5_stored", read_data1, 32'h1234_5678);
    @(negedge clk);
    write_reg  = 5'd5;
    write_data = 32'hffff_ffff;
    reg_write  = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("arst_rd1", read_data1, '0);
    check("arst_rd2", read_data2, '0);
    @(posedge clk);
    #1;
    check("arst_edge_r5", read_data1, '0);
    @(negedge clk);
    reset     = 1'b0;
    reg_write = 1'b0;
    #1;
    check("arst_after_r5", read_data1, '0);
    check("arst_after_r1", read_data2, '0);

    // First write after reset release commits
    do_write(5'd9, 32'h0bad_f00d);
    read_both(5'd9, 5'd9);
    check("post_rst_write", read_data1, 32'h0bad_f00d);

    // Enable gating
    do_write(5'd7, 32'h1111_0007);
    read_both(5'd7, 5'd7);
    write_reg = 5'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      write_data = 32'h5555_0000 + 32'(i);
      @(posedge clk);
      #1;
      check("gate_hold", read_data1, 32'h1111_0007);
    end
    do_write(5'd7, 32'hcafe_f00d);
    #1;
    check("gate_capture", read_data2, 32'hcafe_f00d);

    // Back-to-back writes and bit-exact extremes
    do_write(5'd8, 32'h0000_0001);
    do_write(5'd8, 32'h0000_0002);
    do_write(5'd31, 32'h8000_0001);
    read_both(5'd8, 5'd31);
    check("b2b_last_wins", read_data1, 32'h0000_0002);
    check("r31_bitexact", read_data2, 32'h8000_0001);
    read_both(5'd7, 5'd9);
    check("r7_indep", read_data1, 32'hcafe_f00d);
    check("r9_indep", read_data2, 32'h0bad_f00d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
